// File: rtl/ex_wb_arbiter_pkg.sv
// ex_wb_arbiter_pkg: shared widths, source ids and slot entry type for the write-back arbiter
package ex_wb_arbiter_pkg;
    localparam int N_SRC = 3;
    localparam int DATA_W = 64;
    localparam int REG_W = 6;
    localparam int PTR_W = $clog2(N_SRC);
    typedef enum logic [PTR_W-1:0] {
        SRC_ALU = 2'd0,
        SRC_MULDIV = 2'd1,
        SRC_LSU = 2'd2
    } src_id_e;
    localparam logic [REG_W-1:0] ZERO_REG = '0;
    typedef struct packed {
        logic [REG_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wb_entry_t;
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(N_SRC - 1)) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/ex_wb_arbiter_if.sv
// ex_wb_arbiter_if: execute-unit result buses and register-file write port
interface ex_wb_arbiter_if;
    import ex_wb_arbiter_pkg::*;
    logic [N_SRC-1:0] src_valid;
    logic [N_SRC-1:0] src_ready;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC*REG_W-1:0] src_reg;
    logic wb_we;
    logic [REG_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    modport master (
        output src_valid, src_data, src_reg,
        input src_ready, wb_we, wb_addr, wb_data
    );
    modport slave (
        input src_valid, src_data, src_reg,
        output src_ready, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/ex_wb_rr_arbiter.sv
// ex_wb_rr_arbiter: picks the first request at or after ptr, wrapping modulo N
module ex_wb_rr_arbiter #(
    parameter int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input logic [N-1:0] req,
    input logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic any_grant
);
    logic [W:0] sum;
    // scan offsets from farthest to nearest so the nearest request to ptr wins
    always_comb begin
        grant_idx = '0;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (W+1)'(k);
            sum = (sum >= (W+1)'(N)) ? sum - (W+1)'(N) : sum;
            grant_idx = req[sum[W-1:0]] ? sum[W-1:0] : grant_idx;
        end
    end
    assign any_grant = |req;
    assign grant = any_grant ? N'(1) << grant_idx : '0;
endmodule

// File: rtl/ex_wb_arbiter.sv
// ex_wb_arbiter: buffers one result per execute unit and drains them round-robin to the register file
module ex_wb_arbiter
    import ex_wb_arbiter_pkg::*;
(
    input logic clk,
    input logic rst_n,
    input logic flush,
    ex_wb_arbiter_if.slave bus,
    output logic busy,
    output logic [31:0] conflict_cnt
);
    logic [N_SRC-1:0] slot_v;
    wb_entry_t slot [N_SRC];
    logic [PTR_W-1:0] ptr;
    logic [N_SRC-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic any_grant;
    logic write_ok;
    ex_wb_rr_arbiter #(.N(N_SRC)) u_rr (
        .req(slot_v),
        .ptr(ptr),
        .grant(grant),
        .grant_idx(grant_idx),
        .any_grant(any_grant)
    );
    assign bus.src_ready = ~slot_v | grant;
    assign busy = |slot_v;
    assign write_ok = any_grant & ~flush;
    // slot occupancy: drain on grant, refill on handshake, flush empties everything
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) slot_v <= '0;
        else slot_v <= flush ? '0 : (slot_v & ~grant) | (bus.src_valid & bus.src_ready);
    // slot payload only matters while its valid bit is set, so it needs no reset
    always_ff @(posedge clk)
        for (int i = 0; i < N_SRC; i++)
            if (bus.src_valid[i] & bus.src_ready[i])
                slot[i] <= '{r: bus.src_reg[i*REG_W +: REG_W], d: bus.src_data[i*DATA_W +: DATA_W]};
    // round-robin pointer moves past whichever source was just served
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else ptr <= any_grant ? next_ptr(grant_idx) : ptr;
    // register-file port: r0 entries are consumed silently, address/data hold when idle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.wb_we <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
        end else begin
            bus.wb_we <= write_ok & (slot[grant_idx].r != ZERO_REG);
            bus.wb_addr <= write_ok ? slot[grant_idx].r : bus.wb_addr;
            bus.wb_data <= write_ok ? slot[grant_idx].d : bus.wb_data;
        end
    // count cycles with contention for the write port, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) conflict_cnt <= '0;
        else if (!flush && $countones(slot_v) > 1 && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
endmodule

// File: tb/tb_ex_wb_arbiter.sv
// tb_ex_wb_arbiter: directed stimulus checked against a slot/queue model of the write-back arbiter
module tb_ex_wb_arbiter;
    import ex_wb_arbiter_pkg::*;
    logic clk = 0;
    logic rst_n = 0;
    logic flush = 0;
    logic busy;
    logic [31:0] conflict_cnt;
    int total = 0;
    int bad = 0;
    ex_wb_arbiter_if bus ();
    ex_wb_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus),
        .busy(busy),
        .conflict_cnt(conflict_cnt)
    );
    always #5 clk = ~clk;

    bit mv [N_SRC];
    logic [DATA_W-1:0] md [N_SRC];
    logic [REG_W-1:0] mr [N_SRC];
    int mptr;
    bit mwe;
    logic [REG_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic [31:0] mcnt;
    int mg, occ;
    bit rdy [N_SRC];
    int cg;
    logic [N_SRC-1:0] exp_rdy;
    bit exp_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N_SRC; k++)
            if (mv[(mptr + k) % N_SRC]) return (mptr + k) % N_SRC;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) mv[i] = 0;
            mptr = 0;
            mwe = 0;
            maddr = 0;
            mdata = 0;
            mcnt = 0;
        end else begin
            mg = pick();
            occ = 0;
            for (int i = 0; i < N_SRC; i++) begin
                rdy[i] = !mv[i] || mg == i;
                occ += int'(mv[i]);
            end
            if (!flush && occ > 1 && mcnt != 32'hFFFF_FFFF) mcnt++;
            mwe = 0;
            if (mg >= 0) begin
                mptr = (mg + 1) % N_SRC;
                mv[mg] = 0;
                if (!flush) begin
                    mwe = mr[mg] != 0;
                    maddr = mr[mg];
                    mdata = md[mg];
                end
            end
            for (int i = 0; i < N_SRC; i++)
                if (flush) mv[i] = 0;
                else if (bus.src_valid[i] && rdy[i]) begin
                    mv[i] = 1;
                    md[i] = bus.src_data[i*DATA_W +: DATA_W];
                    mr[i] = bus.src_reg[i*REG_W +: REG_W];
                end
        end
    end

    initial forever begin
        @(negedge clk);
        cg = pick();
        exp_busy = 0;
        for (int i = 0; i < N_SRC; i++) begin
            exp_rdy[i] = !mv[i] || cg == i;
            exp_busy |= mv[i];
        end
        chk("model_wb_we", 64'(bus.wb_we), 64'(mwe));
        if (mwe) begin
            chk("model_wb_addr", 64'(bus.wb_addr), 64'(maddr));
            chk("model_wb_data", bus.wb_data, mdata);
        end
        chk("model_busy", 64'(busy), 64'(exp_busy));
        chk("model_ready", 64'(bus.src_ready), 64'(exp_rdy));
        chk("model_conflict", 64'(conflict_cnt), 64'(mcnt));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int i, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
        bus.src_reg[i*REG_W +: REG_W] = r;
        bus.src_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        bus.src_valid = '0;
        bus.src_data = '0;
        bus.src_reg = '0;
        tick();
        tick();
        rst_n = 1;
        chk("rst_we", 64'(bus.wb_we), 0);
        chk("rst_addr", 64'(bus.wb_addr), 0);
        chk("rst_data", bus.wb_data, 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cnt", 64'(conflict_cnt), 0);
        chk("rst_ready", 64'(bus.src_ready), 64'h7);

        set_src(int'(SRC_ALU), 6'd5, 64'h1234);
        bus.src_valid = 3'b001;
        tick();
        bus.src_valid = '0;
        chk("t1_ready0_held", 64'(bus.src_ready[0]), 1);
        tick();
        chk("t1_we", 64'(bus.wb_we), 1);
        chk("t1_addr", 64'(bus.wb_addr), 5);
        chk("t1_data", bus.wb_data, 64'h1234);
        chk("t1_ready0", 64'(bus.src_ready[0]), 1);
        tick();
        chk("t1_pulse", 64'(bus.wb_we), 0);

        do_reset();
        set_src(int'(SRC_ALU), 6'd1, 64'hA);
        set_src(int'(SRC_MULDIV), 6'd2, 64'hB);
        set_src(int'(SRC_LSU), 6'd3, 64'hC);
        bus.src_valid = 3'b111;
        tick();
        bus.src_valid = '0;
        chk("t2_ready1_low", 64'(bus.src_ready[1]), 0);
        chk("t2_ready2_low", 64'(bus.src_ready[2]), 0);
        tick();
        chk("t2_w1_addr", 64'(bus.wb_addr), 1);
        chk("t2_w1_data", bus.wb_data, 64'hA);
        chk("t2_ready2_still_low", 64'(bus.src_ready[2]), 0);
        tick();
        chk("t2_w2_addr", 64'(bus.wb_addr), 2);
        chk("t2_w2_data", bus.wb_data, 64'hB);
        tick();
        chk("t2_w3_we", 64'(bus.wb_we), 1);
        chk("t2_w3_addr", 64'(bus.wb_addr), 3);
        chk("t2_w3_data", bus.wb_data, 64'hC);
        chk("t2_conflict", 64'(conflict_cnt), 2);
        tick();
        chk("t2_idle", 64'(bus.wb_we), 0);

        set_src(int'(SRC_ALU), 6'd10, 64'h100);
        set_src(int'(SRC_MULDIV), 6'd11, 64'h101);
        bus.src_valid = 3'b011;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3_we", 64'(bus.wb_we), 1);
            chk("t3_alt_addr", 64'(bus.wb_addr), (k % 2 == 1) ? 64'd11 : 64'd10);
        end
        bus.src_valid = '0;
        repeat (3) tick();
        chk("t3_drained", 64'(busy), 0);

        do_reset();
        set_src(int'(SRC_LSU), 6'd0, 64'hDEAD);
        bus.src_valid = 3'b100;
        tick();
        bus.src_valid = '0;
        tick();
        chk("t4_no_we", 64'(bus.wb_we), 0);
        chk("t4_busy", 64'(busy), 0);
        chk("t4_ready2", 64'(bus.src_ready[2]), 1);
        set_src(int'(SRC_ALU), 6'd7, 64'h77);
        set_src(int'(SRC_LSU), 6'd9, 64'h99);
        bus.src_valid = 3'b101;
        tick();
        bus.src_valid = '0;
        tick();
        chk("t4_ptr0_first", 64'(bus.wb_addr), 7);
        tick();
        chk("t4_second", 64'(bus.wb_addr), 9);

        do_reset();
        set_src(int'(SRC_ALU), 6'd12, 64'h12);
        set_src(int'(SRC_MULDIV), 6'd13, 64'h13);
        set_src(int'(SRC_LSU), 6'd20, 64'hBAD);
        bus.src_valid = 3'b011;
        tick();
        bus.src_valid = 3'b100;
        flush = 1;
        tick();
        flush = 0;
        bus.src_valid = '0;
        chk("t5_we", 64'(bus.wb_we), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_ready", 64'(bus.src_ready), 64'h7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_write", 64'(bus.wb_we), 0);
        end

        do_reset();
        set_src(int'(SRC_ALU), 6'd1, 64'h1);
        set_src(int'(SRC_MULDIV), 6'd2, 64'h2);
        set_src(int'(SRC_LSU), 6'd3, 64'h3);
        bus.src_valid = 3'b111;
        tick();
        bus.src_valid = '0;
        tick();
        chk("t6_we_before", 64'(bus.wb_we), 1);
        chk("t6_cnt_before", 64'(conflict_cnt), 1);
        #1 rst_n = 0;
        #1;
        chk("t6_async_we", 64'(bus.wb_we), 0);
        chk("t6_async_busy", 64'(busy), 0);
        chk("t6_async_cnt", 64'(conflict_cnt), 0);
        tick();
        rst_n = 1;
        set_src(int'(SRC_MULDIV), 6'd33, 64'h5555);
        bus.src_valid = 3'b010;
        tick();
        bus.src_valid = '0;
        tick();
        chk("t6_after_we", 64'(bus.wb_we), 1);
        chk("t6_after_addr", 64'(bus.wb_addr), 33);
        chk("t6_after_data", bus.wb_data, 64'h5555);
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
